// File: rtl/veri_bellek_denetleyici.sv
// veri_bellek_denetleyici
// Main-memory-side responder for the data cache's block interface.
// A dirty-block writeback and/or a block fill are accepted together while
// idle. The writeback always goes first. Each block is serialised into
// word beats on a ready-handshaked memory port. The filled block is returned
// with a one-cycle "block arrived" pulse.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   obek_iste_i/obek_adresi_i  fill request and address (low 4 bits ignored)
//   kirli_obek_yaz_i           writeback request
//   kirli_obek_adresi_i        writeback address (low 4 bits ignored)
//   kirli_veri_obegi_i         writeback block data
//   veri_obegi_o               filled block; held until the next fill completes
//   anabellekten_obek_geldi_o  one-cycle pulse: fill complete
//   geri_yazma_bitti_o         one-cycle pulse: writeback complete
//   mesgul_o                   high whenever the controller is not idle
//   bellek_istek_o             beat request valid
//   bellek_yaz_o               1 = write beat, 0 = read beat
//   bellek_adres_o             word-aligned beat address
//   bellek_yaz_veri_o          write beat data
//   bellek_hazir_i             memory accepts/completes the beat at this edge
//   bellek_oku_veri_i          read data, valid with bellek_hazir_i on reads
module veri_bellek_denetleyici #(
  parameter int KELIME_BIT = 32,
  parameter int OBEK_BIT   = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  obek_iste_i,
  input  logic [31:0]           obek_adresi_i,
  input  logic                  kirli_obek_yaz_i,
  input  logic [31:0]           kirli_obek_adresi_i,
  input  logic [OBEK_BIT-1:0]   kirli_veri_obegi_i,
  output logic [OBEK_BIT-1:0]   veri_obegi_o,
  output logic                  anabellekten_obek_geldi_o,
  output logic                  geri_yazma_bitti_o,
  output logic                  mesgul_o,
  output logic                  bellek_istek_o,
  output logic                  bellek_yaz_o,
  output logic [31:0]           bellek_adres_o,
  output logic [KELIME_BIT-1:0] bellek_yaz_veri_o,
  input  logic                  bellek_hazir_i,
  input  logic [KELIME_BIT-1:0] bellek_oku_veri_i
);

  localparam int VURUS_SAYISI = OBEK_BIT / KELIME_BIT;
  localparam int VW           = $clog2(VURUS_SAYISI);
  localparam logic [VW-1:0] SON_VURUS = VW'(VURUS_SAYISI - 1);
  localparam logic [31:0]   KELIME_BAYT = 32'(KELIME_BIT / 8);

  typedef enum logic [1:0] {BOSTA, GERI_YAZ, OKU, TESLIM} durum_t;

  durum_t                durum_reg, durum_next;
  logic [VW-1:0]         vurus_reg;
  logic [31:0]           geri_adres_reg;
  logic [31:0]           oku_adres_reg;
  logic [OBEK_BIT-1:0]   kirli_veri_reg;
  logic                  oku_bekliyor_reg;
  logic [KELIME_BIT-1:0] okunan_reg [VURUS_SAYISI];
  logic [OBEK_BIT-1:0]   veri_obegi_reg;
  logic                  geri_bitti_reg;

  logic [KELIME_BIT-1:0] kirli_kelime [VURUS_SAYISI];
  logic [OBEK_BIT-1:0]   okunan_obek;
  logic [31:0]           vurus_ofset;
  logic                  son_vurus;

  // Word views of the latched writeback block and the fill buffer.
  for (genvar gi = 0; gi < VURUS_SAYISI; gi++) begin : g_kelime
    assign kirli_kelime[gi] = kirli_veri_reg[gi*KELIME_BIT +: KELIME_BIT];
    assign okunan_obek[gi*KELIME_BIT +: KELIME_BIT] = okunan_reg[gi];
  end

  assign vurus_ofset = 32'(vurus_reg) * KELIME_BAYT;
  assign son_vurus   = (vurus_reg == SON_VURUS) && bellek_hazir_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_reg <= BOSTA;
    end else begin
      durum_reg <= durum_next;
    end
  end

  // The beat request comes straight from the state register. An asynchronous
  // reset therefore withdraws it at once.
  always_comb begin
    durum_next        = durum_reg;
    bellek_istek_o    = 1'b0;
    bellek_yaz_o      = 1'b0;
    bellek_adres_o    = 32'h0;
    bellek_yaz_veri_o = '0;
    unique case (durum_reg)
      BOSTA: begin
        if (kirli_obek_yaz_i) begin
          durum_next = GERI_YAZ;
        end else if (obek_iste_i) begin
          durum_next = OKU;
        end
      end
      GERI_YAZ: begin
        bellek_istek_o    = 1'b1;
        bellek_yaz_o      = 1'b1;
        bellek_adres_o    = geri_adres_reg + vurus_ofset;
        bellek_yaz_veri_o = kirli_kelime[vurus_reg];
        if (son_vurus) begin
          durum_next = oku_bekliyor_reg ? OKU : BOSTA;
        end
      end
      OKU: begin
        bellek_istek_o = 1'b1;
        bellek_adres_o = oku_adres_reg + vurus_ofset;
        if (son_vurus) begin
          durum_next = TESLIM;
        end
      end
      TESLIM: begin
        durum_next = BOSTA;
      end
      default: durum_next = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vurus_reg        <= '0;
      geri_adres_reg   <= 32'h0;
      oku_adres_reg    <= 32'h0;
      kirli_veri_reg   <= '0;
      oku_bekliyor_reg <= 1'b0;
      veri_obegi_reg   <= '0;
      geri_bitti_reg   <= 1'b0;
      for (int i = 0; i < VURUS_SAYISI; i++) begin
        okunan_reg[i] <= '0;
      end
    end else begin
      geri_bitti_reg <= 1'b0;
      unique case (durum_reg)
        BOSTA: begin
          vurus_reg <= '0;
          if (kirli_obek_yaz_i || obek_iste_i) begin
            geri_adres_reg   <= kirli_obek_adresi_i & ~32'hF;
            oku_adres_reg    <= obek_adresi_i & ~32'hF;
            kirli_veri_reg   <= kirli_veri_obegi_i;
            oku_bekliyor_reg <= obek_iste_i;
          end
        end
        GERI_YAZ: begin
          if (bellek_hazir_i) begin
            // The counter wraps to 0 after the last beat. That leaves it
            // ready for the read phase.
            vurus_reg <= vurus_reg + 1'b1;
            if (vurus_reg == SON_VURUS) begin
              geri_bitti_reg <= 1'b1;
            end
          end
        end
        OKU: begin
          if (bellek_hazir_i) begin
            okunan_reg[vurus_reg] <= bellek_oku_veri_i;
            vurus_reg             <= vurus_reg + 1'b1;
          end
        end
        TESLIM: begin
          veri_obegi_reg <= okunan_obek;
        end
        default: ;
      endcase
    end
  end

  // In the delivery cycle, the assembled buffer is presented directly.
  // Afterwards the registered copy holds it, so the next fill can reuse
  // the buffer.
  assign veri_obegi_o              = (durum_reg == TESLIM) ? okunan_obek : veri_obegi_reg;
  assign anabellekten_obek_geldi_o = (durum_reg == TESLIM);
  assign geri_yazma_bitti_o        = geri_bitti_reg;
  assign mesgul_o                  = (durum_reg != BOSTA);

endmodule

// File: tb/tb_veri_bellek_denetleyici.sv
module tb_veri_bellek_denetleyici;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         obek_iste_i;
  logic [31:0]  obek_adresi_i;
  logic         kirli_obek_yaz_i;
  logic [31:0]  kirli_obek_adresi_i;
  logic [127:0] kirli_veri_obegi_i;
  logic [127:0] veri_obegi_o;
  logic         anabellekten_obek_geldi_o;
  logic         geri_yazma_bitti_o;
  logic         mesgul_o;
  logic         bellek_istek_o;
  logic         bellek_yaz_o;
  logic [31:0]  bellek_adres_o;
  logic [31:0]  bellek_yaz_veri_o;
  logic         bellek_hazir_i;
  logic [31:0]  bellek_oku_veri_i;

  veri_bellek_denetleyici dut (
    .clk_i                     (clk),
    .rst_i                     (rst_i),
    .obek_iste_i               (obek_iste_i),
    .obek_adresi_i             (obek_adresi_i),
    .kirli_obek_yaz_i          (kirli_obek_yaz_i),
    .kirli_obek_adresi_i       (kirli_obek_adresi_i),
    .kirli_veri_obegi_i        (kirli_veri_obegi_i),
    .veri_obegi_o              (veri_obegi_o),
    .anabellekten_obek_geldi_o (anabellekten_obek_geldi_o),
    .geri_yazma_bitti_o        (geri_yazma_bitti_o),
    .mesgul_o                  (mesgul_o),
    .bellek_istek_o            (bellek_istek_o),
    .bellek_yaz_o              (bellek_yaz_o),
    .bellek_adres_o            (bellek_adres_o),
    .bellek_yaz_veri_o         (bellek_yaz_veri_o),
    .bellek_hazir_i            (bellek_hazir_i),
    .bellek_oku_veri_i         (bellek_oku_veri_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory contents as seen by the bench's memory model; words are created on first read.
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    int          cyc;
    logic        yaz;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        hz;
  } beat_t;

  // Per-run observation logs: every cycle with a beat request, pulses, busy flag.
  beat_t        log_q [$];
  int           geldi_cyc [$];
  logic [127:0] geldi_veri [$];
  int           bitti_cyc [$];
  logic         mesgul_log [0:255];
  int           cyc;
  int           wait_cnt;
  logic [127:0] last_blk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [127:0] exp_block(input logic [31:0] adr);
    logic [31:0] b;
    b = adr & ~32'hF;
    return {mem_read(b + 32'd12), mem_read(b + 32'd8), mem_read(b + 32'd4), mem_read(b)};
  endfunction

  task automatic clear_logs();
    log_q.delete();
    geldi_cyc.delete();
    geldi_veri.delete();
    bitti_cyc.delete();
    cyc = 0;
    wait_cnt = 0;
  endtask

  // Acts as the memory for n cycles.
  // Mode 0: always ready.
  // Mode 1: two wait cycles before each beat.
  // Mode 2: random readiness.
  task automatic run_cycles(input int n, input int mode);
    logic hz;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      if (cyc < 256) mesgul_log[cyc] = mesgul_o;
      if (anabellekten_obek_geldi_o === 1'b1) begin
        geldi_cyc.push_back(cyc);
        geldi_veri.push_back(veri_obegi_o);
      end
      if (geri_yazma_bitti_o === 1'b1) bitti_cyc.push_back(cyc);
      if (mode == 0) begin
        hz = 1'b1;
      end else if (mode == 1) begin
        if (bellek_istek_o === 1'b1 && wait_cnt < 2) begin
          hz = 1'b0;
          wait_cnt++;
        end else begin
          hz = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        hz = ($urandom_range(0, 3) != 0);
      end
      if (bellek_istek_o === 1'b1)
        log_q.push_back('{cyc, bellek_yaz_o, bellek_adres_o, bellek_yaz_veri_o, hz});
      bellek_hazir_i = hz;
      if (bellek_istek_o === 1'b1 && bellek_yaz_o === 1'b0 && hz)
        bellek_oku_veri_i = mem_read(bellek_adres_o);
      else
        bellek_oku_veri_i = $urandom;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bellek_istek_o, bellek_yaz_o, anabellekten_obek_geldi_o, geri_yazma_bitti_o, mesgul_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {bellek_istek_o, bellek_yaz_o, anabellekten_obek_geldi_o, geri_yazma_bitti_o, mesgul_o});
    end
    checks++;
    if ({bellek_adres_o, bellek_yaz_veri_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h_%h want 0", bellek_adres_o, bellek_yaz_veri_o);
    end
    checks++;
    if (veri_obegi_o !== 128'h0) begin
      errors++;
      $display("FAIL reset_veri: got %h want 0", veri_obegi_o);
    end
    rst_i = 1'b0;
    last_blk = 128'h0;
    $display("test_reset done");
  endtask

  task automatic test_transfers();
    logic         wb, fill;
    int           mode, exp_pulse, exp_bitti, p, last_rd, wr_last;
    logic [31:0]  wb_adr, fill_adr;
    logic [127:0] wb_data, blk, chk_blk;
    logic         use_chk;
    logic         ey [$];
    logic [31:0]  ea [$];
    logic [31:0]  ed [$];
    for (int s = 0; s < 12; s++) begin
      exp_pulse = -1;
      exp_bitti = -1;
      use_chk   = 1'b0;
      chk_blk   = 128'h0;
      wb_data   = {$urandom, $urandom, $urandom, $urandom};
      wb_adr    = $urandom;
      fill_adr  = $urandom;
      mode      = 2;
      if (s == 0 || s == 1) begin
        wb = 1'b0; fill = 1'b1; fill_adr = 32'h0000_1234; mode = s;
        mem[32'h1230] = 32'h1111_1111; mem[32'h1234] = 32'h2222_2222;
        mem[32'h1238] = 32'h3333_3333; mem[32'h123C] = 32'h4444_4444;
        use_chk = 1'b1;
        chk_blk = 128'h44444444_33333333_22222222_11111111;
        exp_pulse = (s == 0) ? 5 : 13;
      end else if (s == 2) begin
        wb = 1'b1; fill = 1'b1; mode = 0;
        wb_adr = 32'h0000_5670; fill_adr = 32'h0000_1230;
        wb_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        use_chk = 1'b1;
        chk_blk = 128'h44444444_33333333_22222222_11111111;
        exp_bitti = 5; exp_pulse = 9;
      end else if (s == 3) begin
        wb = 1'b1; fill = 1'b0; mode = 0; wb_adr = 32'h0000_9ABC;
        exp_bitti = 5;
      end else begin
        wb = 1'($urandom_range(0, 1));
        fill = wb ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // Reference: writeback words low-first, then fill words low-first.
      ey.delete(); ea.delete(); ed.delete();
      if (wb) for (int k = 0; k < 4; k++) begin
        ey.push_back(1'b1);
        ea.push_back((wb_adr & ~32'hF) + 32'(4 * k));
        ed.push_back(wb_data[32*k +: 32]);
      end
      if (fill) for (int k = 0; k < 4; k++) begin
        ey.push_back(1'b0);
        ea.push_back((fill_adr & ~32'hF) + 32'(4 * k));
        ed.push_back(32'h0);
      end
      blk = fill ? exp_block(fill_adr) : 128'h0;

      clear_logs();
      @(negedge clk);
      kirli_obek_yaz_i = wb;    kirli_obek_adresi_i = wb_adr;
      kirli_veri_obegi_i = wb_data;
      obek_iste_i = fill;       obek_adresi_i = fill_adr;
      run_cycles(1, mode);
      kirli_obek_yaz_i = 1'b0;  obek_iste_i = 1'b0;
      run_cycles(59, mode);

      p = 0; last_rd = -1; wr_last = -1;
      foreach (log_q[i]) begin
        checks++;
        if (log_q[i].cyc != i + 1) begin
          errors++;
          $display("FAIL s%0d contig: request at cycle %0d want %0d", s, log_q[i].cyc, i + 1);
        end
        checks++;
        if (p >= ea.size()) begin
          errors++;
          $display("FAIL s%0d extra_beat: cycle %0d adr %h beyond %0d beats", s, log_q[i].cyc, log_q[i].adr, ea.size());
        end else begin
          if (log_q[i].yaz !== ey[p] || log_q[i].adr !== ea[p]) begin
            errors++;
            $display("FAIL s%0d beat%0d: got yaz=%b adr=%h want yaz=%b adr=%h", s, p, log_q[i].yaz, log_q[i].adr, ey[p], ea[p]);
          end
          if (ey[p] && log_q[i].wd !== ed[p]) begin
            errors++;
            $display("FAIL s%0d beat%0d data: got %h want %h", s, p, log_q[i].wd, ed[p]);
          end
          if (log_q[i].hz) begin
            if (ey[p]) wr_last = log_q[i].cyc; else last_rd = log_q[i].cyc;
            p++;
          end
        end
      end
      checks++;
      if (p != ea.size()) begin
        errors++;
        $display("FAIL s%0d beat_count: got %0d want %0d", s, p, ea.size());
      end
      checks++;
      if (geldi_cyc.size() != (fill ? 1 : 0)) begin
        errors++;
        $display("FAIL s%0d geldi_count: got %0d want %0d", s, geldi_cyc.size(), fill ? 1 : 0);
      end else if (fill) begin
        checks++;
        if (geldi_cyc[0] != last_rd + 1 || (exp_pulse >= 0 && geldi_cyc[0] != exp_pulse)) begin
          errors++;
          $display("FAIL s%0d geldi_cycle: got %0d want %0d (table %0d)", s, geldi_cyc[0], last_rd + 1, exp_pulse);
        end
        checks++;
        if (geldi_veri[0] !== blk || (use_chk && geldi_veri[0] !== chk_blk)) begin
          errors++;
          $display("FAIL s%0d block: got %h want %h", s, geldi_veri[0], blk);
        end
        last_blk = blk;
      end
      checks++;
      if (bitti_cyc.size() != (wb ? 1 : 0)) begin
        errors++;
        $display("FAIL s%0d bitti_count: got %0d want %0d", s, bitti_cyc.size(), wb ? 1 : 0);
      end else if (wb) begin
        checks++;
        if (bitti_cyc[0] != wr_last + 1 || (exp_bitti >= 0 && bitti_cyc[0] != exp_bitti)) begin
          errors++;
          $display("FAIL s%0d bitti_cycle: got %0d want %0d (table %0d)", s, bitti_cyc[0], wr_last + 1, exp_bitti);
        end
      end
      checks++;
      if (mesgul_o !== 1'b0 || veri_obegi_o !== last_blk) begin
        errors++;
        $display("FAIL s%0d idle_hold: got mesgul=%b veri=%h want 0 %h", s, mesgul_o, veri_obegi_o, last_blk);
      end
      $display("transfer s%0d wb=%b fill=%b mode=%0d beats=%0d", s, wb, fill, mode, p);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, want;
    int          wc;
    a = 32'h0000_3008;
    b = 32'h0000_4FFC;
    clear_logs();
    @(negedge clk);
    obek_iste_i = 1'b1; obek_adresi_i = a;
    run_cycles(1, 0);
    obek_adresi_i = b; kirli_obek_yaz_i = 1'b1; kirli_obek_adresi_i = 32'h0000_7770;
    run_cycles(3, 0);
    kirli_obek_yaz_i = 1'b0;
    run_cycles(3, 0);
    obek_iste_i = 1'b0;
    run_cycles(8, 0);
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL busy_beats: got %0d want 8", log_q.size());
    end
    wc = 0;
    foreach (log_q[i]) begin
      want = (i < 4) ? (32'h3000 + 32'(4 * i)) : (32'h4FF0 + 32'(4 * (i - 4)));
      if (log_q[i].yaz) wc++;
      checks++;
      if (log_q[i].adr !== want || log_q[i].cyc != ((i < 4) ? i + 1 : i + 3)) begin
        errors++;
        $display("FAIL busy_beat%0d: got adr=%h cyc=%0d want adr=%h cyc=%0d", i, log_q[i].adr, log_q[i].cyc, want, (i < 4) ? i + 1 : i + 3);
      end
    end
    checks++;
    if (wc != 0) begin
      errors++;
      $display("FAIL busy_writes: got %0d want 0", wc);
    end
    checks++;
    if (mesgul_log[5] !== 1'b1 || mesgul_log[6] !== 1'b0) begin
      errors++;
      $display("FAIL busy_mesgul: got c5=%b c6=%b want 1 0", mesgul_log[5], mesgul_log[6]);
    end
    checks++;
    if (geldi_cyc.size() != 2) begin
      errors++;
      $display("FAIL busy_pulses: got %0d want 2", geldi_cyc.size());
    end else begin
      checks++;
      if (geldi_cyc[0] != 5 || geldi_cyc[1] != 11 || geldi_veri[1] !== exp_block(b)) begin
        errors++;
        $display("FAIL busy_fill: got cyc %0d,%0d blk %h want 5,11 %h", geldi_cyc[0], geldi_cyc[1], geldi_veri[1], exp_block(b));
      end
      last_blk = exp_block(b);
    end
    $display("test_busy_ignore beats=%0d", log_q.size());
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(negedge clk);
    obek_iste_i = 1'b1; obek_adresi_i = 32'h0000_2468;
    run_cycles(1, 0);
    obek_iste_i = 1'b0;
    run_cycles(3, 0);
    checks++;
    if (log_q.size() != 4 || bellek_istek_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got %0d requests istek=%b want 4 1", log_q.size(), bellek_istek_o);
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if ({bellek_istek_o, bellek_yaz_o, anabellekten_obek_geldi_o, geri_yazma_bitti_o, mesgul_o} !== 5'b0
        || bellek_adres_o !== 32'h0 || bellek_yaz_veri_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_async: got istek=%b mesgul=%b adr=%h want 0 0 0", bellek_istek_o, mesgul_o, bellek_adres_o);
    end
    checks++;
    if (veri_obegi_o !== 128'h0) begin
      errors++;
      $display("FAIL mid_veri: got %h want 0", veri_obegi_o);
    end
    run_cycles(3, 0);
    rst_i = 1'b0;
    checks++;
    if (geldi_cyc.size() != 0 || log_q.size() != 4) begin
      errors++;
      $display("FAIL mid_no_pulse: got pulses=%0d requests=%0d want 0 4", geldi_cyc.size(), log_q.size());
    end
    clear_logs();
    @(negedge clk);
    obek_iste_i = 1'b1; obek_adresi_i = 32'h0000_1234;
    run_cycles(1, 0);
    obek_iste_i = 1'b0;
    run_cycles(9, 0);
    checks++;
    if (log_q.size() != 4 || log_q[0].adr !== 32'h1230 || log_q[3].adr !== 32'h123C) begin
      errors++;
      $display("FAIL post_beats: got %0d requests want 4 at 1230..123C", log_q.size());
    end
    checks++;
    if (geldi_cyc.size() != 1 || geldi_cyc[0] != 5
        || geldi_veri[0] !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL post_fill: got %0d pulses want 1 at cycle 5 with 4444..1111", geldi_cyc.size());
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_i = 1'b0;
    obek_iste_i = 1'b0;
    obek_adresi_i = 32'h0;
    kirli_obek_yaz_i = 1'b0;
    kirli_obek_adresi_i = 32'h0;
    kirli_veri_obegi_i = 128'h0;
    bellek_hazir_i = 1'b0;
    bellek_oku_veri_i = 32'h0;
    #2 rst_i = 1'b1;
    test_reset();
    test_transfers();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
